// File: rtl/prog_mem_loader_pkg.sv
// Shared definitions for the program-memory loader and the fetch stage.
// The halt encoding lives here so halt injection and load termination agree.
package prog_mem_loader_pkg;

    localparam int          PM_ADDR_W    = 12;
    localparam int          PM_DEPTH     = 1 << PM_ADDR_W;
    localparam int          PM_DATA_W    = 32;
    localparam int          PM_BYTE_W    = 8;
    localparam logic [31:0] PM_HALT_WORD = 32'hFC00_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

endpackage

// File: rtl/prog_mem_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
// slave = loader side, master = stream source / memory / pipeline side.
interface prog_mem_loader_if
    import prog_mem_loader_pkg::*;
#(
    parameter int ADDR_W = PM_ADDR_W
);
    logic                  start;
    logic [PM_BYTE_W-1:0]  in_byte;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [PM_DATA_W-1:0]  mem_wdata;
    logic                  stall_db;
    logic                  done;
    logic                  overflow;
    logic [ADDR_W:0]       word_count;

    modport slave (
        input  start, in_byte, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata,
               stall_db, done, overflow, word_count
    );

    modport master (
        output start, in_byte, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata,
               stall_db, done, overflow, word_count
    );

endinterface

// File: rtl/prog_mem_loader_byte_assembler.sv
// Collects four accepted bytes into a big-endian word; the word is presented
// combinationally together with the fourth byte so the loader can latch it.
module prog_mem_loader_byte_assembler
    import prog_mem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_accept,
    input  logic                 i_clear,
    input  logic [PM_BYTE_W-1:0] i_byte,
    output logic [PM_DATA_W-1:0] o_word,
    output logic                 o_word_ready
);

    logic [23:0] r_shift;
    logic [1:0]  r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_accept) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_count <= r_count + 2'd1;
        end
    end

    // Counter wraps after the fourth byte, so the next word starts clean.
    assign o_word       = {r_shift, i_byte};
    assign o_word_ready = i_accept && (r_count == 2'd3);

endmodule

// File: rtl/prog_mem_loader.sv
// Program-memory loader: streams bytes into consecutive words from address 0,
// holding the pipeline in debug stall until a halt word or a full memory.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no load since reset; waiting for start
//  ST_RECV  | accepting bytes of the current word, pipeline stalled
//  ST_WRITE | one-cycle program-memory write of the assembled word
//  ST_DONE  | load finished (halt or full); stall released, await start
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int          ADDR_W    = PM_ADDR_W,
    parameter logic [31:0] HALT_WORD = PM_HALT_WORD
)(
    input  logic              clk,
    input  logic              rst_n,
    prog_mem_loader_if.slave  bus
);

    load_state_t          r_state;
    load_state_t          w_next_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [PM_DATA_W-1:0] r_mem_wdata;
    logic [ADDR_W:0]      r_word_count;
    logic                 r_overflow;

    logic                 w_accept;
    logic                 w_clear;
    logic                 w_advance;
    logic                 w_set_ovf;
    logic [PM_DATA_W-1:0] w_word;
    logic                 w_word_ready;

    assign w_accept = (r_state == ST_RECV) && bus.in_valid;

    prog_mem_loader_byte_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_accept     (w_accept),
        .i_clear      (w_clear),
        .i_byte       (bus.in_byte),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_advance    = 1'b0;
        w_set_ovf    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_next_state = ST_RECV;
                    w_clear      = 1'b1;
                end
            end
            ST_RECV: begin
                if (w_word_ready) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Halt has priority: a halt in the last slot is not an overflow.
                if (r_mem_wdata == HALT_WORD) begin
                    w_next_state = ST_DONE;
                end else if (r_addr == {ADDR_W{1'b1}}) begin
                    w_next_state = ST_DONE;
                    w_set_ovf    = 1'b1;
                end else begin
                    w_next_state = ST_RECV;
                    w_advance    = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_clear) begin
                r_addr       <= '0;
                r_word_count <= '0;
                r_overflow   <= 1'b0;
            end
            // Write port registers only change here, so they hold between writes.
            if (w_word_ready) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_word;
            end
            if (r_state == ST_WRITE) begin
                r_word_count <= r_word_count + 1'b1;
            end
            if (w_advance) begin
                r_addr <= r_addr + 1'b1;
            end
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = (r_state == ST_RECV);
    assign bus.mem_we     = (r_state == ST_WRITE);
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.stall_db   = (r_state == ST_RECV) || (r_state == ST_WRITE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.overflow   = r_overflow;
    assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: a word-level model of the expected
// writes is checked against both a full-size and a 3-bit-address build.
module tb_prog_mem_loader;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic sel   = 1'b0;
    logic       tb_start = 1'b0;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_byte  = 8'h00;

    always #5 clk = ~clk;

    prog_mem_loader_if #(.ADDR_W(12)) if12 ();
    prog_mem_loader_if #(.ADDR_W(3))  if3  ();

    assign if12.start    = tb_start & ~sel;
    assign if12.in_valid = tb_valid & ~sel;
    assign if12.in_byte  = tb_byte;
    assign if3.start     = tb_start & sel;
    assign if3.in_valid  = tb_valid & sel;
    assign if3.in_byte   = tb_byte;

    prog_mem_loader #(.ADDR_W(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(if12.slave));
    prog_mem_loader #(.ADDR_W(3))  dut3  (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    logic        c_we, c_ready, c_stall, c_done, c_ovf;
    logic [31:0] c_addr, c_data, c_wc;
    assign c_we    = sel ? if3.mem_we   : if12.mem_we;
    assign c_ready = sel ? if3.in_ready : if12.in_ready;
    assign c_stall = sel ? if3.stall_db : if12.stall_db;
    assign c_done  = sel ? if3.done     : if12.done;
    assign c_ovf   = sel ? if3.overflow : if12.overflow;
    assign c_addr  = sel ? 32'(if3.mem_addr)   : 32'(if12.mem_addr);
    assign c_data  = sel ? if3.mem_wdata       : if12.mem_wdata;
    assign c_wc    = sel ? 32'(if3.word_count) : 32'(if12.word_count);

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  stream[$];
    int unsigned exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] obs_data[$];
    int          m_idx, m_words;
    logic        m_ovf, m_ends, m_pend, m_end_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic flush_model();
        exp_addr.delete();
        exp_data.delete();
        m_pend     = 1'b0;
        m_end_seen = 1'b0;
    endtask

    // Expected writes follow directly from the byte stream: four bytes per
    // word, stop after the halt word or once the memory depth is reached.
    task automatic begin_load(input int depth);
        int k;
        logic [31:0] w;
        flush_model();
        obs_data.delete();
        m_idx = 0; m_ovf = 1'b0; m_ends = 1'b0; k = 0;
        for (int i = 0; i + 3 < stream.size(); i += 4) begin
            w = {stream[i], stream[i+1], stream[i+2], stream[i+3]};
            exp_addr.push_back(k);
            exp_data.push_back(w);
            k++;
            if (w == 32'hFC00_0000) begin m_ends = 1'b1; break; end
            if (k == depth) begin m_ends = 1'b1; m_ovf = 1'b1; break; end
        end
        m_words = k;
        @(posedge clk); #1;
        tb_start = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0;
        @(negedge clk);
        chk("start_stall", 32'(c_stall), 1);
        chk("start_done_clr", 32'(c_done), 0);
        chk("start_ovf_clr", 32'(c_ovf), 0);
        chk("start_wc_clr", c_wc, 0);
        @(posedge clk); #1;
    endtask

    task automatic feed(input int n, input int gap_max, input int start_at);
        logic rdy, acc;
        for (int i = 0; i < n; i++) begin
            tb_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            tb_valid = 1'b1;
            tb_byte  = stream[i];
            if (i == start_at) tb_start = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                @(negedge clk);
                rdy = c_ready;
                @(posedge clk); #1;
                tb_start = 1'b0;
                if (rdy) acc = 1'b1;
            end
            if (!acc) begin
                n_vec++; n_err++;
                $display("FAIL feed_timeout: byte %0d not accepted, in_ready %0b", i, c_ready);
                tb_valid = 1'b0;
                return;
            end
        end
        tb_valid = 1'b0;
    endtask

    task automatic wait_end();
        for (int t = 0; t < 400 && !m_end_seen; t++) @(posedge clk);
        n_vec++;
        if (!m_end_seen) begin
            n_err++;
            $display("FAIL wait_end: load did not finish, done %0b pending %0d", c_done, exp_addr.size());
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_pend) begin
                chk("end_done", 32'(c_done), 1);
                chk("end_stall", 32'(c_stall), 0);
                chk("end_wc", c_wc, 32'(m_words));
                chk("end_ovf", 32'(c_ovf), 32'(m_ovf));
                m_pend     = 1'b0;
                m_end_seen = 1'b1;
            end
            if (c_we) begin
                if (exp_addr.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_write: addr %08h data %08h", c_addr, c_data);
                end else begin
                    chk("wr_addr", c_addr, 32'(exp_addr[0]));
                    chk("wr_data", c_data, exp_data[0]);
                    chk("wr_ready_low", 32'(c_ready), 0);
                    chk("wr_stall", 32'(c_stall), 1);
                    chk("wr_wc", c_wc, 32'(m_idx));
                    obs_data.push_back(c_data);
                    void'(exp_addr.pop_front());
                    void'(exp_data.pop_front());
                    m_idx++;
                    if (exp_addr.size() == 0 && m_ends) m_pend = 1'b1;
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(if12.in_ready), 0);
        chk({tag, "_we"},    32'(if12.mem_we), 0);
        chk({tag, "_addr"},  32'(if12.mem_addr), 0);
        chk({tag, "_wdata"}, if12.mem_wdata, 0);
        chk({tag, "_stall"}, 32'(if12.stall_db), 0);
        chk({tag, "_done"},  32'(if12.done), 0);
        chk({tag, "_ovf"},   32'(if12.overflow), 0);
        chk({tag, "_wc"},    32'(if12.word_count), 0);
    endtask

    logic [7:0] s_basic[$] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20,
                               8'hFC, 8'h00, 8'h00, 8'h00};
    logic [7:0] s_fresh[$] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hFC, 8'h00, 8'h00, 8'h00};
    logic [7:0] s_part[$]  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk_all_zero("reset");
        chk("reset_small_ready", 32'(if3.in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic load, valid held high
        stream = s_basic;
        begin_load(4096);
        feed(stream.size(), 0, -1);
        wait_end();
        chk("basic_n_writes", 32'(obs_data.size()), 3);
        if (obs_data.size() == 3) begin
            chk("basic_w0_lit", obs_data[0], 32'h2001_0005);
            chk("basic_w1_lit", obs_data[1], 32'h0022_1820);
            chk("basic_w2_lit", obs_data[2], 32'hFC00_0000);
        end
        chk("basic_wc_lit", 32'(if12.word_count), 3);
        chk("basic_done_lit", 32'(if12.done), 1);

        // Same stream with random gaps; also restarts from DONE
        stream = s_basic;
        begin_load(4096);
        feed(stream.size(), 7, -1);
        wait_end();

        // Start pulse while busy must be ignored
        stream = s_basic;
        begin_load(4096);
        feed(stream.size(), 2, 6);
        wait_end();
        chk("busy_wc_lit", 32'(if12.word_count), 3);

        // Reset after two bytes of the second word
        stream = s_part;
        begin_load(4096);
        feed(stream.size(), 0, -1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        flush_model();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        stream = s_fresh;
        begin_load(4096);
        feed(stream.size(), 1, -1);
        wait_end();
        chk("fresh_w0_lit", (obs_data.size() > 0) ? obs_data[0] : 32'hDEAD_BEEF, 32'hA1B2_C3D4);

        // Overflow on the 3-bit-address build
        sel = 1'b1;
        stream.delete();
        for (int k = 0; k < 9; k++) begin
            stream.push_back(8'h10 + 8'(k));
            stream.push_back(8'h00);
            stream.push_back(8'h00);
            stream.push_back(8'(k));
        end
        begin_load(8);
        feed(32, 1, -1);
        wait_end();
        chk("ovf_wc_lit", c_wc, 8);
        chk("ovf_flag_lit", 32'(c_ovf), 1);
        tb_valid = 1'b1;
        tb_byte  = 8'hAA;
        repeat (6) begin
            @(negedge clk);
            chk("no_accept_after_full", 32'(c_ready), 0);
        end
        @(posedge clk); #1;
        tb_valid = 1'b0;

        // Restart after overflow clears the sticky flags
        stream = s_basic;
        begin_load(8);
        feed(stream.size(), 0, -1);
        wait_end();
        chk("restart_ovf_lit", 32'(c_ovf), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
